// File: rtl/ifu_next_pc.sv
// Fetch-stage next-PC selection: sequential, JAL, JALR or conditional branch,
// plus the architectural PC register pc_q that captures the selected address.
module ifu_next_pc #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rstl,
    input  logic [XLEN-1:0] pc,
    input  logic            is_jmp,
    input  logic            jmp_reg,
    input  logic            is_branch,
    input  logic [2:0]      fn3,
    input  logic            eq,
    input  logic            lt,
    input  logic            ltu,
    input  logic [XLEN-1:0] alu_out,
    input  logic [XLEN-1:0] j_imm,
    input  logic [XLEN-1:0] b_imm,
    output logic [XLEN-1:0] pc_next,
    output logic [XLEN-1:0] pc_q
);

    logic            branch_taken;
    logic [XLEN-1:0] pc_reg;

    // funct3 010/011 have no branch encoding and fall through to PC+4.
    always_comb begin
        branch_taken = 1'b0;
        if (is_branch) begin
            case (fn3)
                3'b000:  branch_taken = eq;
                3'b001:  branch_taken = ~eq;
                3'b100:  branch_taken = lt;
                3'b101:  branch_taken = ~lt;
                3'b110:  branch_taken = ltu;
                3'b111:  branch_taken = ~ltu;
                default: branch_taken = 1'b0;
            endcase
        end
    end

    // Reset forces zero combinationally so pc_next and pc_q agree during reset.
    always_comb begin
        pc_next = pc + XLEN'(4);
        if (!rstl) begin
            pc_next = '0;
        end else if (is_jmp && jmp_reg) begin
            pc_next = alu_out;
        end else if (is_jmp) begin
            pc_next = pc + j_imm;
        end else if (branch_taken) begin
            pc_next = pc + b_imm;
        end
    end

    always_ff @(posedge clk or negedge rstl) begin
        if (!rstl) begin
            pc_reg <= '0;
        end else begin
            pc_reg <= pc_next;
        end
    end

    assign pc_q = pc_reg;

endmodule

// File: tb/tb_ifu_next_pc.sv
// Scoreboard bench for ifu_next_pc: directed vectors push expected PCs,
// a monitor process pops and compares them against the DUT outputs.
module tb_ifu_next_pc;

    logic        clk;
    logic        rstl;
    logic [31:0] pc;
    logic        is_jmp;
    logic        jmp_reg;
    logic        is_branch;
    logic [2:0]  fn3;
    logic        eq;
    logic        lt;
    logic        ltu;
    logic [31:0] alu_out;
    logic [31:0] j_imm;
    logic [31:0] b_imm;
    logic [31:0] pc_next;
    logic [31:0] pc_q;

    typedef struct {
        string       name;
        bit          sel_q;
        logic [31:0] exp;
    } item_t;

    item_t sb[$];
    event  chk_ev;
    int    n_checks = 0;
    int    n_fail   = 0;

    ifu_next_pc #(.XLEN(32)) dut (
        .clk       (clk),
        .rstl      (rstl),
        .pc        (pc),
        .is_jmp    (is_jmp),
        .jmp_reg   (jmp_reg),
        .is_branch (is_branch),
        .fn3       (fn3),
        .eq        (eq),
        .lt        (lt),
        .ltu       (ltu),
        .alu_out   (alu_out),
        .j_imm     (j_imm),
        .b_imm     (b_imm),
        .pc_next   (pc_next),
        .pc_q      (pc_q)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Monitor: drains the scoreboard each time the stimulus marks outputs as presented.
    initial begin
        forever begin
            @(chk_ev);
            while (sb.size() > 0) begin
                item_t       it;
                logic [31:0] act;
                it  = sb.pop_front();
                act = it.sel_q ? pc_q : pc_next;
                n_checks++;
                if (act !== it.exp) begin
                    n_fail++;
                    $display("FAIL %s: %s got 0x%08h expected 0x%08h",
                             it.name, it.sel_q ? "pc_q" : "pc_next", act, it.exp);
                end else begin
                    $display("check %s: %s = 0x%08h ok",
                             it.name, it.sel_q ? "pc_q" : "pc_next", act);
                end
            end
        end
    end

    task automatic expect_val(input string name, input bit sel_q, input logic [31:0] exp);
        item_t it;
        it.name  = name;
        it.sel_q = sel_q;
        it.exp   = exp;
        sb.push_back(it);
    endtask

    task automatic present();
        #1;
        -> chk_ev;
        #1;
    endtask

    task automatic drive(input logic [31:0] pc_v, input logic j, input logic jr,
                         input logic br, input logic [2:0] f, input logic e,
                         input logic l, input logic lu, input logic [31:0] alu,
                         input logic [31:0] ji, input logic [31:0] bi);
        pc        = pc_v;
        is_jmp    = j;
        jmp_reg   = jr;
        is_branch = br;
        fn3       = f;
        eq        = e;
        lt        = l;
        ltu       = lu;
        alu_out   = alu;
        j_imm     = ji;
        b_imm     = bi;
    endtask

    task automatic vec(input string name, input logic [31:0] pc_v, input logic j,
                       input logic jr, input logic br, input logic [2:0] f,
                       input logic e, input logic l, input logic lu,
                       input logic [31:0] alu, input logic [31:0] ji,
                       input logic [31:0] bi, input logic [31:0] exp);
        @(negedge clk);
        drive(pc_v, j, jr, br, f, e, l, lu, alu, ji, bi);
        expect_val(name, 1'b0, exp);
        present();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] fns [6];
        bit         tv  [6];
        int         sel [6];
        fns = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111};
        tv  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        sel = '{0, 0, 1, 1, 2, 2};

        rstl = 1'b1;
        drive(32'h1234_5678, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0);
        #2 rstl = 1'b0;
        #1;
        expect_val("reset_next", 1'b0, 32'h0);
        expect_val("reset_q", 1'b1, 32'h0);
        present();

        // Release: pc_q holds 0 until the first rising edge.
        @(negedge clk);
        rstl = 1'b1;
        pc   = 32'h0000_1000;
        expect_val("seq_next", 1'b0, 32'h0000_1004);
        expect_val("release_q_hold", 1'b1, 32'h0);
        present();
        @(posedge clk);
        expect_val("first_load_q", 1'b1, 32'h0000_1004);
        present();

        // Mid-operation reset clears both outputs without a clock edge.
        @(negedge clk);
        pc = 32'h1234_5678;
        #2 rstl = 1'b0;
        expect_val("midreset_next", 1'b0, 32'h0);
        expect_val("midreset_q", 1'b1, 32'h0);
        present();
        @(negedge clk);
        rstl = 1'b1;
        expect_val("rel2_next", 1'b0, 32'h1234_567C);
        expect_val("rel2_q_hold", 1'b1, 32'h0);
        present();
        @(posedge clk);
        expect_val("rel2_load_q", 1'b1, 32'h1234_567C);
        present();

        vec("seq_wrap", 32'hFFFF_FFFC, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 32'h0);
        vec("seq_ignores_cmp", 32'h0000_0300, 0, 1, 0, 3'b000, 1, 1, 1,
            32'hDEAD_BEEF, 32'h40, 32'h20, 32'h0000_0304);
        vec("jal_pos", 32'h100, 1, 0, 0, 3'b000, 0, 0, 0, 32'hDEAD_BEEF,
            32'h40, 32'h20, 32'h140);
        vec("jal_neg", 32'h100, 1, 0, 0, 3'b000, 0, 0, 0, 32'hDEAD_BEEF,
            32'hFFFF_FFC0, 32'h20, 32'hC0);
        vec("jal_pos_over_br", 32'h100, 1, 0, 1, 3'b000, 1, 1, 1, 32'hDEAD_BEEF,
            32'h40, 32'h20, 32'h140);
        vec("jal_neg_over_br", 32'h100, 1, 0, 1, 3'b000, 1, 1, 1, 32'hDEAD_BEEF,
            32'hFFFF_FFC0, 32'h20, 32'hC0);
        vec("jalr_odd", 32'h100, 1, 1, 0, 3'b000, 0, 0, 0, 32'h8000_0001,
            32'h40, 32'h20, 32'h8000_0001);
        vec("jalr_over_br", 32'h100, 1, 1, 1, 3'b000, 1, 1, 1, 32'h8000_0001,
            32'h40, 32'h20, 32'h8000_0001);

        // Branches: only the comparator selected by fn3 is set to the taken value.
        for (int i = 0; i < 6; i++) begin
            bit v;
            bit e;
            bit l;
            bit lu;
            for (int t = 0; t < 2; t++) begin
                v  = (t == 0) ? tv[i] : !tv[i];
                e  = (sel[i] == 0) ? v : !v;
                l  = (sel[i] == 1) ? v : !v;
                lu = (sel[i] == 2) ? v : !v;
                if (t == 0) begin
                    vec($sformatf("br_f%0d_taken_pos", fns[i]), 32'h200, 0, 0, 1, fns[i],
                        e, l, lu, 0, 32'h40, 32'h20, 32'h220);
                    vec($sformatf("br_f%0d_taken_neg", fns[i]), 32'h200, 0, 0, 1, fns[i],
                        e, l, lu, 0, 32'h40, 32'hFFFF_FFE0, 32'h1E0);
                end else begin
                    vec($sformatf("br_f%0d_not_taken", fns[i]), 32'h200, 0, 0, 1, fns[i],
                        e, l, lu, 0, 32'h40, 32'h20, 32'h204);
                end
            end
        end

        vec("br_reserved_010", 32'h200, 0, 0, 1, 3'b010, 1, 1, 1, 0, 32'h40, 32'h20, 32'h204);
        vec("br_reserved_011", 32'h200, 0, 0, 1, 3'b011, 1, 1, 1, 0, 32'h40, 32'h20, 32'h204);
        vec("br_disabled", 32'h200, 0, 0, 0, 3'b000, 1, 1, 1, 0, 32'h40, 32'h20, 32'h204);

        // pc_q captures the combinational result on the next edge.
        @(negedge clk);
        drive(32'h100, 1, 0, 0, 3'b000, 0, 0, 0, 0, 32'h40, 32'h20);
        @(posedge clk);
        expect_val("q_after_jal", 1'b1, 32'h140);
        present();

        #2;
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ifu_next_pc.md
# ifu_next_pc

Next-PC computation unit of the RISC-V core's fetch stage. Each cycle it takes the current PC and the branch/jump decode and compare results. It produces the address of the next instruction: sequential (PC+4), PC-relative jump (JAL), register-indirect jump (JALR) or conditional branch. The result is a combinational `pc_next` plus a registered copy `pc_q` that serves as the architectural PC register.

## Interface
- `XLEN`, default 32 (codebase `XLEN` define): datapath and address width.

Ports (name, direction, width, meaning):
- `clk`  in  1  rising-edge clock for `pc_q`.
- `rstl`  in  1  asynchronous active-low reset.
- `pc`  in  XLEN  address of the current instruction.
- `is_jmp`  in  1  current instruction is JAL or JALR.
- `jmp_reg`  in  1  with `is_jmp`: target comes from `alu_out` (JALR).
- `is_branch`  in  1  current instruction is a conditional branch.
- `fn3`  in  3  branch funct3 field.
- `eq`, `lt`, `ltu`  in  1 each  comparator results: rs1==rs2, signed rs1<rs2, unsigned rs1<rs2.
- `alu_out`  in  XLEN  computed JALR target (rs1+imm).
- `j_imm`  in  XLEN  sign-extended J-type offset.
- `b_imm`  in  XLEN  sign-extended B-type offset.
- `pc_next`  out  XLEN  combinational next-PC.
- `pc_q`  out  XLEN  registered PC.

## Operation
- Priority, highest first:
  1. `rstl`=0 -> `pc_next`=0, regardless of all other inputs.
  2. `is_jmp`=1, `jmp_reg`=1 -> `pc_next`=`alu_out`, passed unmodified (no LSB clearing).
  3. `is_jmp`=1, `jmp_reg`=0 -> `pc_next`=`pc`+`j_imm`.
  4. `is_branch`=1 and condition true -> `pc_next`=`pc`+`b_imm`.
  5. Otherwise -> `pc_next`=`pc`+4.
- `is_jmp` overrides `is_branch` if both are set.
- Branch condition by `fn3`:
  - 000 BEQ: `eq`
  - 001 BNE: !`eq`
  - 100 BLT: `lt`
  - 101 BGE: !`lt`
  - 110 BLTU: `ltu`
  - 111 BGEU: !`ltu`
  - 010 and 011: never taken, so the result is `pc`+4.
- Arithmetic:
  - All additions are XLEN-bit two's complement, modulo 2^XLEN; carry-out is discarded.
  - Negative offsets are supplied pre-sign-extended, so `pc`+(-n) equals `pc`-n.
- No alignment checking or exception output is generated.
- `jmp_reg` is ignored when `is_jmp`=0.
- Comparator inputs are ignored when `is_branch`=0.

## Timing
- `pc_next` is purely combinational, with zero-cycle latency from any input change, including `rstl`.
- `pc_q`:
  - Asynchronously cleared to 0 while `rstl`=0.
  - On each rising `clk` with `rstl`=1, loads `pc_next`.
- Reset values: `pc_q`=0 and `pc_next`=0.
- Reset asserted mid-operation: both outputs go to 0 immediately, without waiting for a clock edge.
- Reset release: `pc_q` holds 0 until the first rising edge after deassertion.
- No handshake and no internal state beyond `pc_q`.

## Test plan
- Reset: `rstl` 1->0 with `pc`=0x1234_5678 -> `pc_next`=0 and `pc_q`=0 with no clock edge. Release, then one clock edge -> `pc_q`=`pc_next`.
- Sequential: all control lines 0, `pc`=0x0000_1000 -> `pc_next`=0x0000_1004. With `pc`=0xFFFF_FFFC -> 0x0000_0000 (wrap).
- JAL: `is_jmp`=1, `pc`=0x100.
  - `j_imm`=0x40 -> 0x140.
  - `j_imm`=0xFFFF_FFC0 (-0x40) -> 0xC0.
  - Same again with `is_branch`=1 and a taken condition -> identical results (jump priority).
- JALR: `is_jmp`=1, `jmp_reg`=1, `alu_out`=0x8000_0001, `pc`=0x100 -> `pc_next`=0x8000_0001 (odd value unmasked).
- Branches, with `pc`=0x200 and `b_imm`=±0x20, for each `fn3` in {000, 001, 100, 101, 110, 111}:
  - Condition false -> 0x204.
  - Condition true -> 0x220, and 0x1E0 for the negative offset.
  - Checked pairs: BEQ `eq`=1/0, BNE `eq`=0/1, BLT `lt`=1/0, BGE `lt`=0/1, BLTU `ltu`=1/0, BGEU `ltu`=0/1.
- Reserved `fn3`: `fn3`=010 or 011 with `eq`=`lt`=`ltu`=1 -> 0x204.
